posit_accum_to_p16_es2: RTL

- Pipelined output converter that sits directly downstream of the es=2 posit accumulator.
- Consumes the serialized accumulator value {sgn, scale, fraction, inf, zero} on each done pulse.
- Produces a rounded, saturated 16-bit posit (es=2) for the result writeback path.
- Fully pipelined: fixed 3-cycle latency, one conversion accepted per cycle, no backpressure.

---
 rtl/posit_accum_to_p16_es2.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/posit_accum_to_p16_es2.sv
// Converts the es=2 accumulator value {sgn, scale, fraction, inf, zero} into a
// rounded, saturated posit16 (es=2). Three register stages: decode, pack, round/sign.
module posit_accum_to_p16_es2 #(
  parameter int FBITS_ACCUM = 146
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [FBITS_ACCUM+10:0]  in_accum,
  output logic                     out_valid,
  output logic [15:0]              out_posit,
  output logic                     out_nar,
  output logic                     out_zero
);

  // Valid semantics: no backpressure. in_valid=1 means in_accum is consumed on
  // this edge; out_valid=1 marks the single cycle its result is presented.
  // Outputs hold their previous value whenever out_valid=0.

  logic                   in_sgn, in_inf, in_zero;
  logic signed [7:0]      in_scale;
  logic [FBITS_ACCUM-1:0] in_frac;
  logic signed [6:0]      scale_c;
  logic                   force_max, force_min;

  assign in_sgn   = in_accum[FBITS_ACCUM+10];
  assign in_scale = in_accum[FBITS_ACCUM+9:FBITS_ACCUM+2];
  assign in_frac  = in_accum[FBITS_ACCUM+1:2];
  assign in_inf   = in_accum[1];
  assign in_zero  = in_accum[0];

  always_comb begin
    force_max = 1'b0;
    force_min = 1'b0;
    scale_c   = in_scale[6:0];
    if (in_scale > 8'sd56) begin
      force_max = 1'b1;
      scale_c   = 7'sd56;
    end else if (in_scale < -8'sd56) begin
      force_min = 1'b1;
      scale_c   = -7'sd56;
    end
  end

  // Stage 1: decode
  logic        s1_valid, s1_sgn, s1_inf, s1_zero, s1_fmax, s1_fmin, s1_sticky;
  logic [4:0]  s1_k;
  logic [1:0]  s1_e;
  logic [12:0] s1_frac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_fmax   <= 1'b0;
      s1_fmin   <= 1'b0;
      s1_sticky <= 1'b0;
      s1_k      <= '0;
      s1_e      <= '0;
      s1_frac   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sgn    <= in_sgn;
        s1_inf    <= in_inf;
        s1_zero   <= in_zero;
        s1_fmax   <= force_max;
        s1_fmin   <= force_min;
        s1_sticky <= |in_frac[FBITS_ACCUM-14:0];
        s1_k      <= scale_c[6:2];
        s1_e      <= scale_c[1:0];
        s1_frac   <= in_frac[FBITS_ACCUM-1 -: 13];
      end
    end
  end

  // Stage 2: left-aligned {regime, exponent, fraction}; clamped |k| keeps it inside 32 bits
  logic [31:0] packed_bits;
  logic [3:0]  shamt;

  always_comb begin
    shamt       = 4'd0;
    packed_bits = '0;
    if (!s1_k[4]) begin
      shamt       = s1_k[3:0] + 4'd1;
      packed_bits = ~(32'hFFFF_FFFF >> shamt) | ({1'b0, s1_e, s1_frac, 16'h0000} >> shamt);
    end else begin
      shamt       = ~s1_k[3:0] + 4'd1;
      packed_bits = {1'b1, s1_e, s1_frac, 16'h0000} >> shamt;
    end
  end

  logic        s2_valid, s2_sgn, s2_inf, s2_zero, s2_fmax, s2_fmin, s2_guard, s2_sticky;
  logic [14:0] s2_body;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sgn    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_fmax   <= 1'b0;
      s2_fmin   <= 1'b0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_body   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sgn    <= s1_sgn;
        s2_inf    <= s1_inf;
        s2_zero   <= s1_zero;
        s2_fmax   <= s1_fmax;
        s2_fmin   <= s1_fmin;
        s2_guard  <= packed_bits[16];
        s2_sticky <= s1_sticky | (|packed_bits[15:0]);
        s2_body   <= packed_bits[31:17];
      end
    end
  end

  // Stage 3: round-to-nearest-even, saturate away from 0 and NaR, apply sign
  logic        round_up;
  logic [15:0] rounded;
  logic [14:0] mag;
  logic [15:0] posit_nxt;
  logic        nar_nxt, zero_nxt;

  always_comb begin
    round_up  = s2_guard & (s2_body[0] | s2_sticky);
    rounded   = {1'b0, s2_body} + {15'd0, round_up};
    mag       = rounded[14:0];
    nar_nxt   = 1'b0;
    zero_nxt  = 1'b0;
    if (s2_fmax)                  mag = 15'h7FFF;
    else if (s2_fmin)             mag = 15'h0001;
    else if (rounded[15])         mag = 15'h7FFF;
    else if (rounded[14:0] == '0) mag = 15'h0001;
    posit_nxt = s2_sgn ? (16'h0000 - {1'b0, mag}) : {1'b0, mag};
    if (s2_inf) begin
      posit_nxt = 16'h8000;
      nar_nxt   = 1'b1;
    end else if (s2_zero) begin
      posit_nxt = 16'h0000;
      zero_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= 16'h0000;
      out_nar   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_posit <= posit_nxt;
        out_nar   <= nar_nxt;
        out_zero  <= zero_nxt;
      end
    end
  end

endmodule
